// File: rtl/mobo_states.sv
// mobo_states: shared mobo handshake encodings for the memory port and CPU-side logic
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
package mobo_states;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam int REQ  = 0;
    localparam int WR   = 1;
    localparam int ACK  = 0;
    localparam int BUSY = 1;
    localparam int ERR  = 2;
endpackage

// File: rtl/mobo_ram.sv
// mobo_ram: single-port synchronous RAM with a registered, resettable read port
module mobo_ram #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int AW         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [AW-1:0]         addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);
    logic [WORD_WIDTH-1:0] mem [DEPTH];
    // storage array, deliberately never cleared
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    // read register holds the last completed read; only it clears on reset
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/mobo_mem_port.sv
// mobo_mem_port: mobo handshake responder in front of a wait-stated word RAM
module mobo_mem_port
    import mobo_states::*;
#(
    parameter int WORD_WIDTH  = `WORD_WIDTH,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] mobo_ctrl,
    output logic [WORD_WIDTH-1:0] mobo_stat,
    input  logic [WORD_WIDTH-1:0] addr_in,
    input  logic [WORD_WIDTH-1:0] mobodat_in,
    output logic [WORD_WIDTH-1:0] mobodat_out
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(WAIT_STATES + 2);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [WORD_WIDTH-1:0] addr_q, data_q, stat_n;
    logic wr_q, req, in_range, go, unused;
    assign req = mobo_ctrl[REQ];
    assign unused = ^mobo_ctrl[WORD_WIDTH-1:2];
    assign in_range = addr_q < WORD_WIDTH'(DEPTH);
    assign go = state == WAIT && req && cnt == '0;
    // next state, wait countdown and the status word the next state presents
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        stat_n = '0;
        case (state)
            IDLE: if (req) begin
                state_n = WAIT;
                cnt_n = CW'(WAIT_STATES);
            end
            WAIT: if (!req) state_n = IDLE;
                  else if (cnt != '0) cnt_n = cnt - 1'b1;
                  else state_n = DONE;
            DONE: if (!req) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        stat_n[BUSY] = state_n == WAIT;
        stat_n[ACK] = state_n == DONE;
        stat_n[ERR] = state_n == DONE && !in_range;
    end
    // state, counter and status registers; request fields captured only when leaving IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            mobo_stat <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            mobo_stat <= stat_n;
            if (state == IDLE && req) begin
                addr_q <= addr_in;
                data_q <= mobodat_in;
                wr_q <= mobo_ctrl[WR];
            end
        end
    end
    mobo_ram #(.WORD_WIDTH(WORD_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk(clk),
        .rst(rst),
        .we(go && wr_q && in_range && !rst),
        .re(go && !wr_q && in_range),
        .addr(addr_q[AW-1:0]),
        .wdata(data_q),
        .rdata(mobodat_out)
    );
endmodule

// File: tb/tb_mobo_mem_port.sv
// tb_mobo_mem_port: randomized scoreboard bench for the mobo memory port
module tb_mobo_mem_port;
    localparam int W = 32;
    localparam int DEPTH = 256;
    localparam int WS = 2;
    logic clk = 0;
    logic rst = 1;
    logic [W-1:0] ctrl = '0, addr = '0, din = '0, stat, dout;
    logic [W-1:0] ctrl0 = '0, addr0 = '0, din0 = '0, stat0, dout0;
    int checks = 0;
    int failures = 0;
    logic [W-1:0] mem_m [DEPTH];
    logic [W-1:0] out_m = '0;
    typedef struct {logic err; logic [W-1:0] data;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mobo_mem_port #(.WORD_WIDTH(W), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .mobo_ctrl(ctrl), .mobo_stat(stat),
        .addr_in(addr), .mobodat_in(din), .mobodat_out(dout)
    );
    mobo_mem_port #(.WORD_WIDTH(W), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .mobo_ctrl(ctrl0), .mobo_stat(stat0),
        .addr_in(addr0), .mobodat_in(din0), .mobodat_out(dout0)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every rising ACK consumes one expected completion
    initial begin : monitor
        logic prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (stat[0] && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_err", W'(stat[2]), W'(e.err));
                    check("ack_data", dout, e.data);
                end
            end
            prev = stat[0];
        end
    end

    task automatic txn(input bit wr, input int a, input logic [W-1:0] d,
                       input int abort_at, input int rst_at, input int hold);
        int k, busy_n;
        bit inr;
        inr = a < DEPTH;
        if (abort_at == 0 && rst_at == 0) begin
            if (inr && wr) mem_m[a] = d;
            if (inr && !wr) out_m = mem_m[a];
            sb.push_back('{err: !inr, data: out_m});
        end
        addr = W'(a);
        din = d;
        ctrl = {30'b0, wr, 1'b1};
        k = 0;
        busy_n = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (stat[1]) busy_n++;
            if (stat[0]) break;
            if (k == rst_at) begin
                rst = 1;
                ctrl = '0;
                @(negedge clk);
                rst = 0;
                check("rst_stat", stat, '0);
                check("rst_dout", dout, '0);
                out_m = '0;
                return;
            end
            if (k == abort_at) begin
                ctrl[0] = 0;
                repeat (3) begin
                    @(negedge clk);
                    check("abort_stat", stat, '0);
                end
                return;
            end
            if (k == 1) begin
                addr = $urandom;
                din = $urandom;
                ctrl[W-1:1] = 31'($urandom);
            end
        end
        check("ack_latency", k, WS + 2);
        check("busy_cycles", busy_n, WS + 1);
        repeat (hold) begin
            @(negedge clk);
            check("hold_stat", stat, {29'b0, !inr, 1'b0, 1'b1});
        end
        ctrl[0] = 0;
        @(negedge clk);
        check("idle_stat", stat, '0);
        check("dout_held", dout, out_m);
    endtask

    task automatic txn0(input bit wr, input int a, input logic [W-1:0] d, input logic [W-1:0] exp_dout);
        int k;
        addr0 = W'(a);
        din0 = d;
        ctrl0 = {30'b0, wr, 1'b1};
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            k++;
            if (stat0[0]) break;
        end
        check("ws0_latency", k, 2);
        check("ws0_dout", dout0, exp_dout);
        repeat (4) begin
            @(negedge clk);
            check("ws0_hold", stat0, 32'h1);
        end
        ctrl0 = '0;
        @(negedge clk);
        check("ws0_idle", stat0, '0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_stat", stat, '0);
        check("reset_dout", dout, '0);
        rst = 0;
        for (int i = 0; i < 16; i++) txn(1, i, $urandom, 0, 0, 0);
        txn(1, 3, 5, 0, 0, 0);
        txn(0, 3, 0, 0, 0, 1);
        txn(0, 300, 0, 0, 0, 0);
        txn(1, 7, 9, 2, 0, 0);
        txn(0, 7, 0, 0, 0, 0);
        txn(1, 1, 32'hdead_beef, 0, 1, 0);
        txn(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            int kind, a;
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 2 * DEPTH) : $urandom_range(0, 15);
            txn(1'($urandom_range(0, 1)), a, $urandom,
                kind == 0 ? $urandom_range(1, WS + 1) : 0,
                kind == 1 ? $urandom_range(1, WS + 1) : 0,
                $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        txn0(1, 2, 32'h77, 32'h0);
        txn0(0, 2, 32'h0, 32'h77);
        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
